board_scanner: RTL and testbench
================================

Name: board_scanner

Overview:
- Producer side of the piece-draw interface: walks the 8x8 board-state RAM in row-major order and emits one (x, y, colour) draw request per occupied cell to the piece drawer.
- The drawer converts each request to pixel coordinates and a VGA colour.
- Also tallies black and white pieces per scan for the score display.
- Sits between the game-logic board RAM and the drawer, triggered by a start pulse after each move.

Parameters:
- BOARD_DIM, 8, cells per row/column; must be a power of two.
- COORD_W, 3, log2(BOARD_DIM); width of x/y.
- CNT_W, 7, piece-counter width; holds 0..BOARD_DIM*BOARD_DIM.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- resetn  input  1  synchronous, active-high reset; name kept per codebase, polarity is high-true.
- start  input  1  single-cycle scan request; honoured only in IDLE.
- rd_addr  output  2*COORD_W  board RAM read address = {y, x}.
- rd_data  input  2  cell state one cycle after rd_addr; 11 = black, 10 = white, 0x = empty.
- piece_x  output  COORD_W  column of emitted piece.
- piece_y  output  COORD_W  row of emitted piece.
- piece_colour  output  2  cell code of emitted piece (11 or 10 only).
- piece_valid  output  1  request valid.
- piece_ready  input  1  drawer accepts request.
- busy  output  1  high from the cycle after start is accepted until the DONE cycle inclusive.
- done  output  1  one-cycle pulse at scan end.
- black_count  output  CNT_W  black pieces found in the last completed scan.
- white_count  output  CNT_W  white pieces found in the last completed scan.

Behaviour:
- Reset: state IDLE, x=y=0, rd_addr=0, piece_x/y=0, piece_colour=00, piece_valid=0, busy=0, done=0, both counts=0, working tallies=0.
- Reset mid-scan aborts the scan immediately; any pending request is dropped and counts clear.
- IDLE: on start -> READ. Clear the working tallies and x, y.
- READ: rd_addr={y,x} registered into the RAM this cycle -> CHECK.
- CHECK: sample rd_data.
  - If rd_data[1]=1: latch piece_x=x, piece_y=y, piece_colour=rd_data; increment the matching working tally; set piece_valid -> EMIT.
  - Otherwise: advance the cell.
- Advance cell: x increments; on x=BOARD_DIM-1, x wraps to 0 and y increments. After cell (7,7): -> DONE, else -> READ.
- EMIT: hold piece_valid and payload stable until piece_valid and piece_ready are both high in the same cycle. In that cycle, drop valid and advance the cell as above.
  - A ready asserted in the first EMIT cycle completes the transfer in that cycle.
  - Ready while valid is low is ignored.
- DONE: done=1 for exactly one cycle; copy the working tallies to black_count/white_count; -> IDLE.
- Counts change only in DONE; they hold through the next scan.
- start while not IDLE (READ/CHECK/EMIT/DONE) is ignored and not queued.
- Timing:
  - Empty cell costs 2 cycles.
  - Occupied cell costs 2 + N cycles, N = cycles waiting in EMIT (N≥1).
  - An all-empty board completes in 1 + 128 + 1 cycles from start to done.
- Full board: 64 requests; black_count + white_count = 64, which fits CNT_W=7.

Decomposition:
- Shared package `reversi_pkg`:
  - cell codes CELL_BLACK=2'b11, CELL_WHITE=2'b10, CELL_EMPTY=2'b00.
  - BOARD_DIM, COORD_W.
  - state enum IDLE/READ/CHECK/EMIT/DONE.
- The drawer and the game logic import the same package.
- One natural sub-module: `cell_counter` holds the x/y walk, wrap logic and the last-cell flag. The FSM, handshake and tallies stay in board_scanner.

Test Plan:
- Empty board, start at cycle 0 -> zero piece_valid pulses; done high at cycle 129; counts 0/0; busy low after DONE.
- Standard opening, (3,3)=10, (4,4)=10, (3,4)=11, (4,3)=11, ready tied high -> requests in order (3,3,10), (4,3,11), (3,4,11), (4,4,10); white_count=2, black_count=2.
- Backpressure on the same opening, ready low for 5 cycles per request -> payload stable while valid and not ready; each request accepted exactly once; done delayed by 20 cycles vs the ready-high run.
- Full board alternating 11/10 -> 64 requests; last request (7,7); black_count=32, white_count=32; done one cycle after the final accept plus the DONE cycle.
- start pulsed during EMIT of the second piece -> ignored; exactly one done pulse; counts unchanged from a clean scan.
- resetn high mid-EMIT at (4,3) -> next cycle piece_valid=0, busy=0, counts=0; a fresh start then rescans from (0,0).

Source files
------------

// File: rtl/reversi_pkg.sv
// Shared definitions for the reversi datapath: board geometry, cell codes
// and the board-scanner state encoding.
package reversi_pkg;

    localparam int BOARD_DIM = 8;
    localparam int COORD_W   = 3;
    localparam int CNT_W     = 7;

    localparam logic [1:0] CELL_BLACK = 2'b11;
    localparam logic [1:0] CELL_WHITE = 2'b10;
    localparam logic [1:0] CELL_EMPTY = 2'b00;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CHECK,
        EMIT,
        DONE
    } scan_state_e;

endpackage

// File: rtl/cell_counter.sv
// Row-major walk over the board: x is the fast index, y the slow one.
// last_o flags the final cell so the scanner can finish after it.
module cell_counter #(
    parameter int BOARD_DIM = reversi_pkg::BOARD_DIM,
    parameter int COORD_W   = reversi_pkg::COORD_W
) (
    input  logic               clk,
    input  logic               rst_i,
    input  logic               clear_i,
    input  logic               advance_i,
    output logic [COORD_W-1:0] x_o,
    output logic [COORD_W-1:0] y_o,
    output logic               last_o
);

    localparam logic [COORD_W-1:0] MAX_IDX = COORD_W'(BOARD_DIM - 1);

    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;

    // NOTE: next-state logic gets defaults first so no path can infer a latch.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clear_i) begin
            x_d = '0;
            y_d = '0;
        end else if (advance_i) begin
            // BOARD_DIM is a power of two, so the increment wraps on its own.
            x_d = x_q + COORD_W'(1);
            if (x_q == MAX_IDX) begin
                y_d = y_q + COORD_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign last_o = (x_q == MAX_IDX) && (y_q == MAX_IDX);

endmodule

// File: rtl/board_scanner.sv
// Walks the board RAM and issues one valid/ready draw request per occupied
// cell, tallying black and white pieces for the score display.
module board_scanner #(
    parameter int BOARD_DIM = reversi_pkg::BOARD_DIM,
    parameter int COORD_W   = reversi_pkg::COORD_W,
    parameter int CNT_W     = reversi_pkg::CNT_W
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    output logic [2*COORD_W-1:0] rd_addr,
    input  logic [1:0]           rd_data,
    output logic [COORD_W-1:0]   piece_x,
    output logic [COORD_W-1:0]   piece_y,
    output logic [1:0]           piece_colour,
    output logic                 piece_valid,
    input  logic                 piece_ready,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     black_count,
    output logic [CNT_W-1:0]     white_count
);

    import reversi_pkg::*;

    scan_state_e          state_q;
    logic [COORD_W-1:0]   x, y;
    logic                 last_cell;
    logic                 clear_walk;
    logic                 advance;
    logic [COORD_W-1:0]   piece_x_q, piece_y_q;
    logic [1:0]           colour_q;
    logic                 valid_q, busy_q, done_q;
    logic [CNT_W-1:0]     black_q, white_q;
    logic [CNT_W-1:0]     black_tally_q, white_tally_q;

    assign clear_walk = (state_q == IDLE) && start;
    assign advance    = ((state_q == CHECK) && !rd_data[1]) ||
                        ((state_q == EMIT) && valid_q && piece_ready);

    cell_counter #(
        .BOARD_DIM (BOARD_DIM),
        .COORD_W   (COORD_W)
    ) u_cell_counter (
        .clk       (clk),
        .rst_i     (resetn),
        .clear_i   (clear_walk),
        .advance_i (advance),
        .x_o       (x),
        .y_o       (y),
        .last_o    (last_cell)
    );

    // NOTE: all state here is sequential, so every assignment is non-blocking.
    always_ff @(posedge clk) begin
        if (resetn) begin
            state_q       <= IDLE;
            piece_x_q     <= '0;
            piece_y_q     <= '0;
            colour_q      <= CELL_EMPTY;
            valid_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            black_q       <= '0;
            white_q       <= '0;
            black_tally_q <= '0;
            white_tally_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        black_tally_q <= '0;
                        white_tally_q <= '0;
                        busy_q        <= 1'b1;
                        state_q       <= READ;
                    end
                end
                READ: begin
                    state_q <= CHECK;
                end
                CHECK: begin
                    if (rd_data[1]) begin
                        piece_x_q <= x;
                        piece_y_q <= y;
                        colour_q  <= rd_data;
                        valid_q   <= 1'b1;
                        case (rd_data)
                            CELL_BLACK: black_tally_q <= black_tally_q + CNT_W'(1);
                            CELL_WHITE: white_tally_q <= white_tally_q + CNT_W'(1);
                            default: ;
                        endcase
                        state_q <= EMIT;
                    end else if (last_cell) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        state_q <= READ;
                    end
                end
                EMIT: begin
                    if (valid_q && piece_ready) begin
                        valid_q <= 1'b0;
                        if (last_cell) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            state_q <= READ;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    black_q <= black_tally_q;
                    white_q <= white_tally_q;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rd_addr      = {y, x};
    assign piece_x      = piece_x_q;
    assign piece_y      = piece_y_q;
    assign piece_colour = colour_q;
    assign piece_valid  = valid_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign black_count  = black_q;
    assign white_count  = white_q;

endmodule

// File: tb/tb_board_scanner.sv
// Directed bench for board_scanner: a behavioural board RAM, a ready policy
// with configurable backpressure, and a monitor that records every transfer.
module tb_board_scanner;

    typedef struct packed {
        logic [2:0] x;
        logic [2:0] y;
        logic [1:0] c;
    } req_t;

    typedef struct {
        int pattern;
        int hold;
        int exp_done;
        int exp_black;
        int exp_white;
        int exp_reqs;
    } vec_t;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic       start = 1'b0;
    logic [5:0] rd_addr;
    logic [1:0] rd_data = 2'b00;
    logic [2:0] piece_x, piece_y;
    logic [1:0] piece_colour;
    logic       piece_valid;
    logic       piece_ready = 1'b0;
    logic       busy, done;
    logic [6:0] black_count, white_count;

    logic [1:0] board [64];
    req_t       got [$];
    req_t       exp_q [$];
    int         cyc = 0;
    int         t0 = 0;
    int         hold_cycles = 0;
    int         wait_cnt = 0;
    int         done_pulses = 0;
    int         done_at = 0;
    int         stab_err = 0;
    bit         prev_pending = 1'b0;
    req_t       prev_payload;
    int         n_cmp = 0;
    int         n_fail = 0;
    vec_t       vecs [4];

    always #5 clk = ~clk;

    board_scanner dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .piece_x      (piece_x),
        .piece_y      (piece_y),
        .piece_colour (piece_colour),
        .piece_valid  (piece_valid),
        .piece_ready  (piece_ready),
        .busy         (busy),
        .done         (done),
        .black_count  (black_count),
        .white_count  (white_count)
    );

    // Synchronous-read board RAM: data appears one cycle after the address.
    always @(posedge clk) rd_data <= board[rd_addr];

    always @(posedge clk) cyc <= cyc + 1;

    // Ready policy and transfer monitor, evaluated away from the active edge.
    always @(negedge clk) begin
        if (piece_valid) begin
            piece_ready = (wait_cnt >= hold_cycles);
            wait_cnt++;
            if (prev_pending && ({piece_x, piece_y, piece_colour} != prev_payload))
                stab_err++;
            if (piece_ready) begin
                got.push_back({piece_x, piece_y, piece_colour});
                prev_pending = 1'b0;
                wait_cnt     = 0;
            end else begin
                prev_pending = 1'b1;
                prev_payload = {piece_x, piece_y, piece_colour};
            end
        end else begin
            piece_ready  = (hold_cycles == 0);
            wait_cnt     = 0;
            prev_pending = 1'b0;
        end
        if (done) begin
            done_pulses++;
            done_at = cyc;
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Fills the RAM and builds the expected request list in row-major order.
    task automatic load_board(input int pattern);
        exp_q.delete();
        for (int i = 0; i < 64; i++) begin
            case (pattern)
                0:       board[i] = (i % 3 == 0) ? 2'b01 : 2'b00;
                1:       board[i] = 2'b00;
                default: board[i] = (i % 2 == 0) ? 2'b11 : 2'b10;
            endcase
        end
        if (pattern == 1) begin
            board[3*8+3] = 2'b10;
            board[4*8+4] = 2'b10;
            board[4*8+3] = 2'b11;
            board[3*8+4] = 2'b11;
        end
        for (int yy = 0; yy < 8; yy++)
            for (int xx = 0; xx < 8; xx++)
                if (board[yy*8+xx][1])
                    exp_q.push_back({3'(xx), 3'(yy), board[yy*8+xx]});
    endtask

    task automatic start_scan();
        got.delete();
        done_pulses = 0;
        stab_err    = 0;
        @(negedge clk);
        start = 1'b1;
        t0    = cyc;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
    endtask

    task automatic finish_scan(input int exp_done, input int exp_black,
                               input int exp_white, input int exp_reqs);
        bit seen = 1'b0;
        int n;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (done_pulses > 0) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            check("done_timeout", 0, 1);
            return;
        end
        repeat (3) @(posedge clk);
        #1;
        check("done_cycle", done_at - t0, exp_done);
        check("done_pulses", done_pulses, 1);
        check("busy_after_done", busy, 0);
        check("black_count", black_count, exp_black);
        check("white_count", white_count, exp_white);
        check("stable_payload", stab_err, 0);
        check("req_count", got.size(), exp_reqs);
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("req%0d_xyc", i), got[i], exp_q[i]);
    endtask

    initial begin
        bit hit;

        vecs[0] = '{0, 0, 129,  0,  0,  0};
        vecs[1] = '{1, 0, 133,  2,  2,  4};
        vecs[2] = '{1, 5, 153,  2,  2,  4};
        vecs[3] = '{2, 0, 193, 32, 32, 64};

        repeat (3) @(posedge clk);
        #1 resetn = 1'b0;
        check("rst_valid", piece_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_addr", rd_addr, 0);
        check("rst_xyc", {piece_x, piece_y, piece_colour}, 0);
        check("rst_counts", {black_count, white_count}, 0);

        for (int v = 0; v < 4; v++) begin
            load_board(vecs[v].pattern);
            hold_cycles = vecs[v].hold;
            start_scan();
            finish_scan(vecs[v].exp_done, vecs[v].exp_black,
                        vecs[v].exp_white, vecs[v].exp_reqs);
        end
        check("full_last_req", got.size() == 64 ? got[63] : '0, {3'd7, 3'd7, 2'b10});

        // start pulsed while the second piece is waiting in EMIT.
        load_board(1);
        hold_cycles = 3;
        start_scan();
        hit = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #1;
            if (piece_valid && got.size() == 1) begin
                hit = 1'b1;
                break;
            end
        end
        check("emit2_reached", hit, 1);
        check("counts_hold_black", black_count, 32);
        check("counts_hold_white", white_count, 32);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        finish_scan(145, 2, 2, 4);
        repeat (20) @(posedge clk);
        #1;
        check("no_queued_start", done_pulses, 1);

        // Reset asserted while (4,3) is stalled in EMIT.
        load_board(1);
        hold_cycles = 100;
        start_scan();
        hit = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #1;
            if (piece_valid && piece_x == 3'd4 && piece_y == 3'd3) begin
                hit = 1'b1;
                break;
            end
        end
        check("emit43_reached", hit, 1);
        resetn = 1'b1;
        @(posedge clk); #1;
        check("abort_valid", piece_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_counts", {black_count, white_count}, 0);
        check("abort_addr", rd_addr, 0);
        resetn = 1'b0;
        hold_cycles = 0;
        start_scan();
        finish_scan(133, 2, 2, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
